// File: rtl/grad_xy_unpack_rx_pkg.sv
// Shared LII definitions for the gradient unpack receiver: field layout of a
// packed {gradient_x, gradient_y} beat and the buffered FIFO entry.
package grad_xy_unpack_rx_pkg;

   localparam int LII_PW   = 64;
   localparam int LII_ID_W = 8;

   // Field order matches the packer: x in the upper half, y in the lower half.
   localparam int GX_MSB = 63;
   localparam int GX_LSB = 32;
   localparam int GY_MSB = 31;
   localparam int GY_LSB = 0;

   typedef struct packed {
      logic [LII_PW-1:0]   data;
      logic [LII_ID_W-1:0] src;
   } lii_entry_t;

   localparam int ENTRY_W = $bits(lii_entry_t);

endpackage

// File: rtl/grad_xy_unpack_rx_if.sv
// Bus bundles for the unpack receiver: the LII input channel and one
// AXI-Stream lane towards the kernel.
interface grad_xy_unpack_rx_lii_if
   import grad_xy_unpack_rx_pkg::*;
#(
   parameter int PW  = LII_PW,
   parameter int IDW = LII_ID_W
);
   logic [PW-1:0]  tdata;
   logic           tvalid;
   logic           tready;
   logic [IDW-1:0] src;
   logic [IDW-1:0] dst;

   modport master (output tdata, tvalid, src, dst, input tready);
   modport slave  (input tdata, tvalid, src, dst, output tready);
endinterface

interface grad_xy_unpack_rx_axis_if #(
   parameter int W = 32
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, tvalid, input tready);
   modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/grad_xy_unpack_rx_fifo.sv
// Small synchronous FIFO holding packed beats; the head entry is read straight
// from the storage registers, so a pushed entry is visible the cycle after.
module lii_sync_fifo
   import grad_xy_unpack_rx_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = ENTRY_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the empty mask below hides stale contents.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/grad_xy_unpack_rx.sv
// Gradient unpack receiver: filters LII beats by destination, buffers them and
// splits each beat into independently consumed x/y AXI-Stream lanes.
module grad_xy_unpack_rx
   import grad_xy_unpack_rx_pkg::*;
#(
   parameter int         PW      = LII_PW,
   parameter int         LW      = 32,
   parameter int         DEPTH   = 2,
   parameter logic [7:0] NODE_ID = 8'h00,
   parameter int         CW      = 16
) (
   input  logic                      aclk,
   input  logic                      arst,
   grad_xy_unpack_rx_lii_if.slave    lii_in_p0,
   grad_xy_unpack_rx_axis_if.master  gradient_x_stream,
   grad_xy_unpack_rx_axis_if.master  gradient_y_stream,
   output logic [LII_ID_W-1:0]       head_src,
   output logic [CW-1:0]             drop_cnt,
   output logic                      ce
);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   logic [PW-1:0]      beat;
   lii_entry_t         wr_entry, head;
   logic [ENTRY_W-1:0] head_bits;
   logic               full, empty;
   logic               in_fire, accept, drop;
   logic               x_vld, y_vld, x_fire, y_fire, pop;
   logic               x_done_q, x_done_d, y_done_q, y_done_d;
   logic [CW-1:0]      drop_cnt_q, drop_cnt_d;
   logic [LW-1:0]      x_data, y_data;

   // Ready comes from registered occupancy only, never from the lane readys.
   assign lii_in_p0.tready = ~full & ~arst;

   assign beat    = lii_in_p0.tdata;
   assign in_fire = lii_in_p0.tvalid & lii_in_p0.tready;
   assign accept  = in_fire & (lii_in_p0.dst == NODE_ID);
   assign drop    = in_fire & (lii_in_p0.dst != NODE_ID);

   always_comb begin
      wr_entry      = '0;
      wr_entry.data = beat;
      wr_entry.src  = lii_in_p0.src;
   end

   lii_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk_i   (aclk),
      .rst_i   (arst),
      .push_i  (accept),
      .pop_i   (pop),
      .wdata_i (wr_entry),
      .rdata_o (head_bits),
      .full_o  (full),
      .empty_o (empty)
   );

   assign head   = lii_entry_t'(head_bits);
   assign x_data = head.data[GX_MSB:GX_LSB];
   assign y_data = head.data[GY_MSB:GY_LSB];

   assign x_vld  = ~empty & ~x_done_q;
   assign y_vld  = ~empty & ~y_done_q;
   assign x_fire = x_vld & gradient_x_stream.tready;
   assign y_fire = y_vld & gradient_y_stream.tready;

   // A beat retires only once both halves have been taken, in any order.
   assign pop = ~empty & (x_done_q | x_fire) & (y_done_q | y_fire);

   always_comb begin
      x_done_d   = x_done_q | x_fire;
      y_done_d   = y_done_q | y_fire;
      drop_cnt_d = drop_cnt_q;
      if (pop) begin
         x_done_d = 1'b0;
         y_done_d = 1'b0;
      end
      if (drop) drop_cnt_d = sat_inc(drop_cnt_q);
   end

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         x_done_q   <= 1'b0;
         y_done_q   <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         x_done_q   <= x_done_d;
         y_done_q   <= y_done_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign gradient_x_stream.tvalid = x_vld;
   assign gradient_y_stream.tvalid = y_vld;
   assign gradient_x_stream.tdata  = x_data;
   assign gradient_y_stream.tdata  = y_data;
   assign head_src                 = head.src;
   assign drop_cnt                 = drop_cnt_q;

   assign ce = ~empty & (gradient_x_stream.tready | x_done_q)
                      & (gradient_y_stream.tready | y_done_q);

endmodule

// File: tb/tb_grad_xy_unpack_rx.sv
// Scoreboard bench for grad_xy_unpack_rx: expected lane halves are queued on
// input acceptance and popped by a monitor on every lane transfer.
module tb_grad_xy_unpack_rx;
   import grad_xy_unpack_rx_pkg::*;

   localparam logic [7:0] NODE = 8'h00;
   localparam int         CW   = 16;

   logic clk  = 1'b0;
   logic arst = 1'b1;
   always #5 clk = ~clk;

   grad_xy_unpack_rx_lii_if  lii ();
   grad_xy_unpack_rx_axis_if x_if ();
   grad_xy_unpack_rx_axis_if y_if ();

   logic [7:0]    head_src;
   logic [CW-1:0] drop_cnt;
   logic          ce;

   grad_xy_unpack_rx #(.NODE_ID(NODE), .CW(CW)) dut (
      .aclk              (clk),
      .arst              (arst),
      .lii_in_p0         (lii),
      .gradient_x_stream (x_if),
      .gradient_y_stream (y_if),
      .head_src          (head_src),
      .drop_cnt          (drop_cnt),
      .ce                (ce)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [7:0]  s;
   } exp_t;

   exp_t        xq[$];
   exp_t        yq[$];
   int          tests = 0;
   int          fails = 0;
   int          x_xfers = 0;
   int          y_xfers = 0;
   int          model_drops = 0;
   logic        x_hold = 1'b0;
   logic        y_hold = 1'b0;
   logic [31:0] x_prev = '0;
   logic [31:0] y_prev = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] exp_drops();
      return (model_drops > 65535) ? 16'hFFFF : model_drops[CW-1:0];
   endfunction

   task automatic monitor_cycle();
      exp_t e;
      if (arst) begin
         x_hold = 1'b0;
         y_hold = 1'b0;
         return;
      end
      if (x_hold) check("x_stable", {31'd0, x_if.tvalid, x_if.tdata}, {31'd0, 1'b1, x_prev});
      if (y_hold) check("y_stable", {31'd0, y_if.tvalid, y_if.tdata}, {31'd0, 1'b1, y_prev});
      if (x_if.tvalid && x_if.tready) begin
         x_xfers++;
         tests++;
         if (xq.size() == 0) begin
            fails++;
            $display("FAIL x_extra actual=%h required=no_beat", x_if.tdata);
         end else begin
            e = xq.pop_front();
            check("x_data", {32'd0, x_if.tdata}, {32'd0, e.d});
            check("x_src", {56'd0, head_src}, {56'd0, e.s});
         end
      end
      if (y_if.tvalid && y_if.tready) begin
         y_xfers++;
         tests++;
         if (yq.size() == 0) begin
            fails++;
            $display("FAIL y_extra actual=%h required=no_beat", y_if.tdata);
         end else begin
            e = yq.pop_front();
            check("y_data", {32'd0, y_if.tdata}, {32'd0, e.d});
            check("y_src", {56'd0, head_src}, {56'd0, e.s});
         end
      end
      x_hold = x_if.tvalid & ~x_if.tready;
      y_hold = y_if.tvalid & ~y_if.tready;
      x_prev = x_if.tdata;
      y_prev = y_if.tdata;
      // Reference model: a beat addressed here yields its halves, others count as drops.
      if (lii.tvalid && lii.tready) begin
         if (lii.dst == NODE) begin
            xq.push_back({lii.tdata[63:32], lii.src});
            yq.push_back({lii.tdata[31:0], lii.src});
         end else begin
            model_drops++;
         end
      end
   endtask

   task automatic drive(input logic [63:0] d, input logic [7:0] s, input logic [7:0] dst);
      lii.tdata  = d;
      lii.src    = s;
      lii.dst    = dst;
      lii.tvalid = 1'b1;
   endtask

   task automatic send(input logic [63:0] d, input logic [7:0] s, input logic [7:0] dst);
      logic fired;
      fired = 1'b0;
      drive(d, s, dst);
      for (int i = 0; i < 200 && !fired; i++) begin
         @(negedge clk);
         fired = lii.tready;
         @(posedge clk); #1;
      end
      lii.tvalid = 1'b0;
      if (!fired) begin
         tests++;
         fails++;
         $display("FAIL send_timeout actual=no_accept required=accept");
      end
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      x_if.tready = 1'b1;
      y_if.tready = 1'b1;
      for (int i = 0; i < 500 && !done; i++) begin
         @(posedge clk); #1;
         done = (xq.size() == 0) && (yq.size() == 0);
      end
      @(negedge clk); #1;
      tests++;
      if (!done || x_if.tvalid || y_if.tvalid) begin
         fails++;
         $display("FAIL drain actual=xq%0d_yq%0d_vld%b%b required=empty", xq.size(), yq.size(),
                  x_if.tvalid, y_if.tvalid);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      lii.tvalid  = 1'b0;
      lii.tdata   = '0;
      lii.src     = '0;
      lii.dst     = '0;
      x_if.tready = 1'b0;
      y_if.tready = 1'b0;
      fork
         forever begin
            @(negedge clk);
            monitor_cycle();
         end
         begin
            logic [63:0] d;
            logic        fired;
            int          sx, sy, stalls, idx;

            #3;
            check("rst_tready", {63'd0, lii.tready}, 64'd0);
            check("rst_x_vld", {63'd0, x_if.tvalid}, 64'd0);
            check("rst_y_vld", {63'd0, y_if.tvalid}, 64'd0);
            check("rst_ce", {63'd0, ce}, 64'd0);
            check("rst_head_src", {56'd0, head_src}, 64'd0);
            check("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
            check("rst_tdata", {x_if.tdata, y_if.tdata}, 64'd0);
            #19 arst = 1'b0;
            @(negedge clk);
            check("post_rst_tready", {63'd0, lii.tready}, 64'd1);
            @(posedge clk); #1;

            // Single directed beat
            x_if.tready = 1'b1;
            y_if.tready = 1'b1;
            send(64'h0000_0011_0000_0022, 8'hA5, NODE);
            @(negedge clk); #1;
            check("single_x_vld", {63'd0, x_if.tvalid}, 64'd1);
            check("single_y_vld", {63'd0, y_if.tvalid}, 64'd1);
            check("single_data", {x_if.tdata, y_if.tdata}, 64'h0000_0011_0000_0022);
            check("single_src", {56'd0, head_src}, 64'h0000_0000_0000_00A5);
            check("single_ce", {63'd0, ce}, 64'd1);
            @(posedge clk); #1;
            @(negedge clk); #1;
            check("single_retire", {62'd0, x_if.tvalid, y_if.tvalid}, 64'd0);
            @(posedge clk); #1;

            // Back-to-back stream
            sx = x_xfers; sy = y_xfers; stalls = 0;
            for (int i = 0; i < 16; i++) begin
               drive({$urandom, $urandom}, 8'(i + 1), NODE);
               @(negedge clk);
               if (!lii.tready) stalls++;
               @(posedge clk); #1;
            end
            lii.tvalid = 1'b0;
            @(negedge clk); #1;
            check("stream_stalls", 64'(stalls), 64'd0);
            check("stream_x_xfers", 64'(x_xfers - sx), 64'd16);
            check("stream_y_xfers", 64'(y_xfers - sy), 64'd16);
            @(posedge clk); #1;
            drain();

            // Skewed lanes: y stalls for five cycles
            x_if.tready = 1'b1;
            y_if.tready = 1'b0;
            sx = x_xfers; sy = y_xfers; idx = 0;
            drive({$urandom, $urandom}, 8'h30, NODE);
            for (int cyc = 0; cyc < 60; cyc++) begin
               @(negedge clk); #1;
               if (cyc == 4) begin
                  check("skew_x_once", 64'(x_xfers - sx), 64'd1);
                  check("skew_y_none", 64'(y_xfers - sy), 64'd0);
                  check("skew_x_vld", {63'd0, x_if.tvalid}, 64'd0);
                  check("skew_y_vld", {63'd0, y_if.tvalid}, 64'd1);
                  check("skew_full", {63'd0, lii.tready}, 64'd0);
               end
               fired = lii.tvalid & lii.tready;
               @(posedge clk); #1;
               if (cyc == 4) y_if.tready = 1'b1;
               if (fired) begin
                  idx++;
                  if (idx == 4) break;
                  drive({$urandom, $urandom}, 8'(8'h30 + idx), NODE);
               end
            end
            lii.tvalid = 1'b0;
            check("skew_sent", 64'(idx), 64'd4);
            drain();

            // Misrouted beats interleaved with good ones
            sx = x_xfers;
            send({$urandom, $urandom}, 8'h41, 8'h07);
            send({$urandom, $urandom}, 8'h42, NODE);
            send({$urandom, $urandom}, 8'h43, 8'hFF);
            send({$urandom, $urandom}, 8'h44, NODE);
            send({$urandom, $urandom}, 8'h45, 8'h80);
            drain();
            check("misroute_drops", {48'd0, drop_cnt}, 64'd3);
            check("misroute_beats", 64'(x_xfers - sx), 64'd2);

            // Full FIFO, simultaneous lane fires, new beat pending
            x_if.tready = 1'b0;
            y_if.tready = 1'b0;
            send({$urandom, $urandom}, 8'h51, NODE);
            send({$urandom, $urandom}, 8'h52, NODE);
            drive({$urandom, $urandom}, 8'h53, NODE);
            @(negedge clk); #1;
            check("full_tready", {63'd0, lii.tready}, 64'd0);
            @(posedge clk); #1;
            x_if.tready = 1'b1;
            y_if.tready = 1'b1;
            @(negedge clk); #1;
            check("full_pop_cycle_tready", {63'd0, lii.tready}, 64'd0);
            check("full_pop_ce", {63'd0, ce}, 64'd1);
            @(posedge clk); #1;
            @(negedge clk); #1;
            check("after_pop_tready", {63'd0, lii.tready}, 64'd1);
            @(posedge clk); #1;
            lii.tvalid = 1'b0;
            @(negedge clk); #1;
            check("push_pop_tready", {63'd0, lii.tready}, 64'd1);
            check("push_pop_x_vld", {63'd0, x_if.tvalid}, 64'd1);
            @(posedge clk); #1;
            drain();

            // Randomized traffic and lane back-pressure
            fired = 1'b0;
            for (int i = 0; i < 400; i++) begin
               x_if.tready = ($urandom_range(0, 3) != 0);
               y_if.tready = ($urandom_range(0, 3) != 0);
               if (!lii.tvalid || fired) begin
                  if ($urandom_range(0, 2) != 0) begin
                     d = {$urandom, $urandom};
                     drive(d, 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'h33 : NODE);
                  end else begin
                     lii.tvalid = 1'b0;
                  end
               end
               @(negedge clk);
               fired = lii.tvalid & lii.tready;
               @(posedge clk); #1;
            end
            lii.tvalid = 1'b0;
            drain();
            check("random_drops", {48'd0, drop_cnt}, {48'd0, exp_drops()});

            // Drop counter saturation
            drive(64'd0, 8'h00, 8'hEE);
            repeat (65541) @(posedge clk);
            #1;
            lii.tvalid = 1'b0;
            @(negedge clk); #1;
            check("drop_sat_model", {48'd0, drop_cnt}, {48'd0, exp_drops()});
            check("drop_sat", {48'd0, drop_cnt}, 64'h0000_0000_0000_FFFF);
            @(posedge clk); #1;

            // Reset with two beats buffered and the x half already taken
            x_if.tready = 1'b0;
            y_if.tready = 1'b0;
            send({$urandom, $urandom}, 8'h61, NODE);
            send({$urandom, $urandom}, 8'h62, NODE);
            x_if.tready = 1'b1;
            @(posedge clk); #1;
            x_if.tready = 1'b0;
            y_if.tready = 1'b1;
            #1;
            check("pre_rst_ce", {63'd0, ce}, 64'd1);
            check("pre_rst_x_done", {62'd0, x_if.tvalid, y_if.tvalid}, 64'd1);
            arst = 1'b1;
            #1;
            check("mid_rst_vld", {62'd0, x_if.tvalid, y_if.tvalid}, 64'd0);
            check("mid_rst_ce", {63'd0, ce}, 64'd0);
            check("mid_rst_tready", {63'd0, lii.tready}, 64'd0);
            xq.delete();
            yq.delete();
            model_drops = 0;
            @(posedge clk); #1;
            @(posedge clk); #2;
            arst = 1'b0;
            @(posedge clk); #1;
            check("post_rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
            check("post_rst_empty", {62'd0, x_if.tvalid, y_if.tvalid}, 64'd0);
            x_if.tready = 1'b1;
            y_if.tready = 1'b1;
            sx = x_xfers;
            send(64'hCAFE_0001_BEEF_0002, 8'h77, NODE);
            drain();
            check("post_rst_beats", 64'(x_xfers - sx), 64'd1);
            check("final_queues", 64'(xq.size() + yq.size()), 64'd0);
         end
      join_any
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
